addfield: RTL and testbench
===========================

# addfield

Parametrised field inserter for the RMII/byte-stream Ethernet transmit path. It inserts or overwrites a run of FLEN constant bytes, such as a source MAC, VLAN tag or EtherType, at byte offset OFFSET of every packet on a valid/byte stream. It sits between packet assembly and the CRC/preamble stages. Insert, replace and pass-through modes are selectable per packet.

## Interface
- OFFSET, default 6: byte offset of the field within the packet; must be ≥1.
- FLEN, default 6: field length in bytes; must be ≥1.
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  reset, asynchronous assertion, active low.
- i_mode  in  2  0 = pass, 1 = insert, 2 = replace, 3 = pass.
- i_field  in  8*FLEN  field value; the MSB byte is emitted first.
- i_v  in  1  input byte valid; one packet is one contiguous run of i_v high.
- i_byte  in  8  input byte.
- o_v  out  1  output byte valid.
- o_byte  out  8  output byte.
- o_busy  out  1  high whenever the state is not IDLE.
- o_err  out  1  one-cycle pulse when a packet is dropped.

## Operation
- States are IDLE, HEAD, FIELD, BODY, DRAIN and DROP.
- Mode and field are captured on the first i_v cycle in IDLE and held for the whole packet. Changes to i_mode or i_field mid-packet have no effect.
- Counter pos counts accepted input bytes. It saturates at OFFSET+FLEN and clears in IDLE.
- Pass mode:
  - Output equals input delayed 1 cycle.
  - The state returns to IDLE on the cycle after i_v falls.
- Replace mode:
  - Latency is 1 cycle and packet length is unchanged.
  - Input bytes OFFSET..OFFSET+FLEN-1 are replaced by field bytes 0..FLEN-1.
  - If the packet ends inside the field, output ends with the input; the remaining field bytes are not emitted.
- Insert mode, input byte k arriving at cycle t0+k for a packet of N bytes:
  - k < OFFSET: byte k is output at t0+1+k.
  - Field byte j is output at t0+1+OFFSET+j.
  - k ≥ OFFSET: byte k is output at t0+1+FLEN+k.
  - o_v stays high continuously for N+FLEN cycles.
  - N < OFFSET: the packet passes unchanged and no field is added.
  - N = OFFSET: the field is appended at the end.
- State transitions:
  - IDLE→HEAD on i_v.
  - HEAD→FIELD when pos reaches OFFSET (insert/replace modes only).
  - FIELD→BODY after FLEN field bytes.
  - BODY/HEAD/FIELD→DRAIN when i_v falls in insert mode with N ≥ OFFSET; otherwise they go to IDLE.
  - DRAIN lasts FLEN cycles, emitting buffered bytes, then goes to IDLE.
- Required inter-packet gap in insert mode is ≥FLEN idle cycles; with exactly FLEN, output packets are back-to-back.
- Gap violation (i_v high while in DRAIN):
  - Go to DROP and pulse o_err.
  - DRAIN output completes correctly.
  - The incoming bytes are discarded until i_v is low.
  - Return to IDLE once both the drain and the dropped packet have ended.

## Timing
- Reset values: o_v=0, o_byte=0, o_busy=0, o_err=0, state=IDLE, pos=0, delay line cleared.
- All outputs are registered. Minimum latency from i_byte to o_byte is 1 cycle.
- o_busy rises the cycle after the first i_v and falls the cycle after the last o_v.
- o_err is asserted for exactly 1 cycle per dropped packet.
- Reset asserted mid-packet: all outputs go to 0 immediately, with no partial field. The first packet after reset release starts cleanly if i_v rises on or after the first clock edge following release.

## Structure
- Package addfield_pkg holds the mode constants (ADDF_PASS, ADDF_INSERT, ADDF_REPLACE) and the state encoding.
- Sub-module bytedelay: a parametrised DEPTH×(1+8) shift register with async active-low clear. It is instantiated with DEPTH=FLEN for the insert-mode body path.
- The field shift register and the state machine stay in addfield.

## Test plan
- Insert (OFFSET=6, FLEN=6, field 0x021122334455): a 14-byte packet 0x00..0x0D -> 20 output bytes: 00–05, 02 11 22 33 44 55, 06–0D; o_v continuous, first output 1 cycle after the first input.
- Replace: same stimulus with i_mode=2 -> 14 bytes: 00–05, 02 11 22 33 44 55, 0C 0D; latency 1.
- Short packets, insert mode: a 4-byte packet -> 4 bytes unchanged, no drain. A 6-byte packet -> 12 bytes, with the field appended.
- Gap violation: a second packet starting 3 cycles after the first ends -> first packet intact, o_err pulses once, second packet absent from output. A 6-cycle gap -> both packets intact and back-to-back.
- Mid-packet changes: flip i_mode and i_field at byte 3 -> the packet uses the values captured at start; the next packet uses the new values.
- Reset: assert i_reset_n low at output byte 8 -> o_v=0 immediately. After release, a fresh packet is handled correctly.

Source files
------------

// File: rtl/addfield_pkg.sv
// Shared mode constants and state encoding for the addfield byte-stream field inserter.
`timescale 1ns/1ps
package addfield_pkg;

  localparam logic [1:0] ADDF_PASS    = 2'd0;
  localparam logic [1:0] ADDF_INSERT  = 2'd1;
  localparam logic [1:0] ADDF_REPLACE = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StHead,
    StField,
    StBody,
    StDrain,
    StDrop
  } state_e;

  function automatic logic is_field_mode(input logic [1:0] mode);
    return (mode == ADDF_INSERT) || (mode == ADDF_REPLACE);
  endfunction

endpackage

// File: rtl/addfield_bytedelay.sv
// Fixed-depth shift register of valid+byte pairs; holds the body bytes displaced by an inserted field.
`timescale 1ns/1ps
module bytedelay #(
  parameter int unsigned DEPTH = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  logic [DEPTH-1:0][8:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = {valid_i, data_i};
    for (int i = 1; i < int'(DEPTH); i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign {valid_o, data_o} = sr_q[DEPTH-1];

endmodule

// File: rtl/addfield.sv
// Inserts or overwrites FLEN constant bytes at byte OFFSET of every packet on a valid/byte stream.
`timescale 1ns/1ps
module addfield
  import addfield_pkg::*;
#(
  parameter int unsigned OFFSET = 6,
  parameter int unsigned FLEN   = 6
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_mode,
  input  logic [8*FLEN-1:0] i_field,
  input  logic              i_v,
  input  logic [7:0]        i_byte,
  output logic              o_v,
  output logic [7:0]        o_byte,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned PosW = $clog2(OFFSET + FLEN + 1);
  localparam int unsigned CntW = $clog2(FLEN + 1);
  localparam logic [PosW-1:0] PosMax  = PosW'(OFFSET + FLEN);
  localparam logic [PosW-1:0] PosOff  = PosW'(OFFSET);
  localparam logic [CntW-1:0] CntLast = CntW'(FLEN - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FLEN);

  state_e            state_q, state_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [CntW-1:0]   fcnt_q, fcnt_d;
  logic [CntW-1:0]   dcnt_q, dcnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [8*FLEN-1:0] field_q, field_d;
  logic              o_v_q, o_v_d;
  logic [7:0]        o_byte_q, o_byte_d;
  logic              o_err_q, o_err_d;

  logic              tap_v;
  logic [7:0]        tap_byte;
  logic              start;
  logic [PosW-1:0]   pos_inc;
  logic [7:0]        field_byte;
  logic              drain_from_field;

  bytedelay #(
    .DEPTH (FLEN)
  ) u_body_delay (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .valid_i (i_v),
    .data_i  (i_byte),
    .valid_o (tap_v),
    .data_o  (tap_byte)
  );

  assign pos_inc          = (pos_q == PosMax) ? pos_q : pos_q + PosW'(1);
  assign field_byte       = field_q[8*FLEN-1 -: 8];
  // Field bytes still owed take priority over the delayed body while draining.
  assign drain_from_field = (fcnt_q != CntFull);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    mode_d   = mode_q;
    field_d  = field_q;
    o_v_d    = 1'b0;
    o_byte_d = 8'h00;
    o_err_d  = 1'b0;
    start    = 1'b0;

    unique case (state_q)
      StIdle: start = i_v;
      StHead: begin
        if (i_v) begin
          o_v_d    = 1'b1;
          o_byte_d = i_byte;
          pos_d    = pos_inc;
          if (pos_inc == PosOff && is_field_mode(mode_q)) state_d = StField;
        end else begin
          state_d = StIdle;
        end
      end
      StField: begin
        if (mode_q == ADDF_INSERT || i_v) begin
          o_v_d    = 1'b1;
          o_byte_d = field_byte;
          field_d  = field_q << 8;
          fcnt_d   = fcnt_q + CntW'(1);
        end
        if (i_v) begin
          pos_d = pos_inc;
          if (fcnt_q == CntLast) state_d = StBody;
        end else if (mode_q == ADDF_INSERT) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StBody: begin
        if (mode_q == ADDF_INSERT) begin
          o_v_d    = tap_v;
          o_byte_d = tap_byte;
        end else begin
          o_v_d    = i_v;
          o_byte_d = i_byte;
        end
        if (i_v) begin
          pos_d = pos_inc;
        end else if (mode_q == ADDF_INSERT) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        o_v_d    = drain_from_field | tap_v;
        o_byte_d = drain_from_field ? field_byte : tap_byte;
        if (drain_from_field) begin
          field_d = field_q << 8;
          fcnt_d  = fcnt_q + CntW'(1);
        end
        // The final drain slot carries no data, so a packet may start there back-to-back.
        if (dcnt_q == CntLast) begin
          state_d = StIdle;
          start   = i_v;
        end else begin
          dcnt_d = dcnt_q + CntW'(1);
          if (i_v) begin
            state_d = StDrop;
            o_err_d = 1'b1;
          end
        end
      end
      StDrop: begin
        if (dcnt_q != CntFull) begin
          o_v_d    = drain_from_field | tap_v;
          o_byte_d = drain_from_field ? field_byte : tap_byte;
          if (drain_from_field) begin
            field_d = field_q << 8;
            fcnt_d  = fcnt_q + CntW'(1);
          end
          dcnt_d = dcnt_q + CntW'(1);
        end
        if (!i_v && dcnt_q >= CntLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d  = (PosOff == PosW'(1) && is_field_mode(i_mode)) ? StField : StHead;
      mode_d   = i_mode;
      field_d  = i_field;
      pos_d    = PosW'(1);
      fcnt_d   = '0;
      dcnt_d   = '0;
      o_v_d    = 1'b1;
      o_byte_d = i_byte;
    end

    if (state_d == StIdle) pos_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
      mode_q   <= ADDF_PASS;
      field_q  <= '0;
      o_v_q    <= 1'b0;
      o_byte_q <= 8'h00;
      o_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
      mode_q   <= mode_d;
      field_q  <= field_d;
      o_v_q    <= o_v_d;
      o_byte_q <= o_byte_d;
      o_err_q  <= o_err_d;
    end
  end

  assign o_v    = o_v_q;
  assign o_byte = o_byte_q;
  assign o_err  = o_err_q;
  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_addfield.sv
// Scoreboard bench for addfield: expected bytes and their output cycles are queued at drive time.
`timescale 1ns/1ps
module tb_addfield;
  import addfield_pkg::*;

  localparam int unsigned OFFSET = 6;
  localparam int unsigned FLEN   = 6;
  localparam logic [47:0] FIELD_A = 48'h021122334455;
  localparam logic [47:0] FIELD_B = 48'hA1B2C3D4E5F6;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [47:0] field = '0;
  logic        iv = 1'b0;
  logic [7:0]  ib = 8'h00;
  logic        ov;
  logic [7:0]  ob;
  logic        busy;
  logic        err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  exp_t exp_q[$];
  exp_t e;

  addfield #(
    .OFFSET (OFFSET),
    .FLEN   (FLEN)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_mode    (mode),
    .i_field   (field),
    .i_v       (iv),
    .i_byte    (ib),
    .o_v       (ov),
    .o_byte    (ob),
    .o_busy    (busy),
    .o_err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: slot m of the output appears at cycle t0+1+m.
  task automatic push_model(input logic [1:0] m, input logic [47:0] f, input int n,
                            input logic [7:0] base, input int t0);
    exp_t x;
    if (m == ADDF_INSERT && n >= int'(OFFSET)) begin
      for (int k = 0; k < n; k++) begin
        if (k == int'(OFFSET)) begin
          for (int j = 0; j < int'(FLEN); j++) begin
            x.b = f[8*(int'(FLEN)-1-j) +: 8];
            x.c = t0 + 1 + int'(OFFSET) + j;
            exp_q.push_back(x);
          end
        end
        x.b = base + 8'(k);
        x.c = t0 + 1 + k + ((k >= int'(OFFSET)) ? int'(FLEN) : 0);
        exp_q.push_back(x);
      end
      if (n == int'(OFFSET)) begin
        for (int j = 0; j < int'(FLEN); j++) begin
          x.b = f[8*(int'(FLEN)-1-j) +: 8];
          x.c = t0 + 1 + int'(OFFSET) + j;
          exp_q.push_back(x);
        end
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (m == ADDF_REPLACE && k >= int'(OFFSET) && k < int'(OFFSET + FLEN))
          x.b = f[8*(int'(OFFSET + FLEN)-1-k) +: 8];
        else
          x.b = base + 8'(k);
        x.c = t0 + 1 + k;
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic send_pkt(input logic [1:0] m, input logic [47:0] f, input int n,
                          input logic [7:0] base, input bit expect_out, input int flip_at,
                          input logic [1:0] m2, input logic [47:0] f2, output int t0);
    t0 = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        t0 = cyc;
        if (expect_out) push_model(m, f, n, base, t0);
      end
      iv = 1'b1;
      ib = base + 8'(k);
      if (flip_at >= 0 && k >= flip_at) begin
        mode  = m2;
        field = f2;
      end else begin
        mode  = m;
        field = f;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iv = 1'b0;
      ib = 8'h00;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_o_v: got %b required 0", ov); end
    checks++; if (ob !== 8'h00) begin errors++; $display("FAIL reset_o_byte: got %h required 00", ob); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_o_busy: got %b required 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_o_err: got %b required 0", err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_insert;
    int t0;
    send_pkt(ADDF_INSERT, FIELD_A, 14, 8'h00, 1'b1, -1, 2'd0, '0, t0);
    idle(7);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ov !== 1'b1) begin
      errors++; $display("FAIL insert_last_slot: got busy=%b v=%b required 1 1", busy, ov); end
    idle(1);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ov !== 1'b0) begin
      errors++; $display("FAIL insert_busy_fall: got busy=%b v=%b required 0 0", busy, ov); end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL insert_missing: got %0d pending required 0", exp_q.size()); end
    idle(3);
  endtask

  task automatic test_replace;
    int t0;
    send_pkt(ADDF_REPLACE, FIELD_A, 14, 8'h00, 1'b1, -1, 2'd0, '0, t0);
    idle(4);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL replace_busy: got %b required 0", busy); end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL replace_missing: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_pass;
    int t0;
    send_pkt(2'd3, FIELD_A, 10, 8'h30, 1'b1, -1, 2'd0, '0, t0);
    idle(4);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL pass_missing: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_short;
    int t0;
    send_pkt(ADDF_INSERT, FIELD_A, 4, 8'h10, 1'b1, -1, 2'd0, '0, t0);
    idle(2);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short4_no_drain: got busy=%b required 0", busy); end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL short4_missing: got %0d pending required 0", exp_q.size()); end
    idle(2);
    send_pkt(ADDF_INSERT, FIELD_A, 6, 8'h20, 1'b1, -1, 2'd0, '0, t0);
    idle(10);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL short6_append: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_gap_violation;
    int t0;
    int err0;
    err0 = err_cnt;
    send_pkt(ADDF_INSERT, FIELD_A, 10, 8'h40, 1'b1, -1, 2'd0, '0, t0);
    idle(3);
    send_pkt(ADDF_INSERT, FIELD_A, 8, 8'h50, 1'b0, -1, 2'd0, '0, t0);
    idle(12);
    @(negedge clk);
    checks++; if (err_cnt - err0 != 1) begin
      errors++; $display("FAIL gap_err_pulses: got %0d required 1", err_cnt - err0); end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL gap_first_intact: got %0d pending required 0", exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back;
    int t0;
    int err0;
    err0 = err_cnt;
    send_pkt(ADDF_INSERT, FIELD_A, 10, 8'h60, 1'b1, -1, 2'd0, '0, t0);
    idle(6);
    send_pkt(ADDF_INSERT, FIELD_B, 8, 8'h80, 1'b1, -1, 2'd0, '0, t0);
    idle(16);
    checks++; if (err_cnt != err0) begin
      errors++; $display("FAIL b2b_no_err: got %0d pulses required 0", err_cnt - err0); end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_missing: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_mid_change;
    int t0;
    send_pkt(ADDF_INSERT, FIELD_A, 14, 8'h90, 1'b1, 3, ADDF_REPLACE, FIELD_B, t0);
    idle(6);
    send_pkt(ADDF_REPLACE, FIELD_B, 14, 8'hA0, 1'b1, -1, 2'd0, '0, t0);
    idle(4);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL midchange_missing: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int t0;
    t0 = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        t0 = cyc;
        push_model(ADDF_INSERT, FIELD_A, 14, 8'hC0, t0);
      end
      iv    = 1'b1;
      ib    = 8'hC0 + 8'(k);
      mode  = ADDF_INSERT;
      field = FIELD_A;
    end
    @(posedge clk); #1;
    checks++; if (ov !== 1'b1 || ob !== 8'h22 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_byte8: got v=%b byte=%h busy=%b required 1 22 1", ov, ob, busy); end
    rst_n = 1'b0;
    iv    = 1'b0;
    ib    = 8'h00;
    #1;
    checks++; if (ov !== 1'b0 || ob !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: got v=%b byte=%h busy=%b err=%b required 0 00 0 0",
                         ov, ob, busy, err); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pkt(ADDF_REPLACE, FIELD_A, 14, 8'hD0, 1'b1, -1, 2'd0, '0, t0);
    idle(4);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL rstmid_fresh: got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (err === 1'b1) err_cnt++;
        if (ov !== 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got byte %h at cycle %0d, required no output", ob, cyc);
          end else begin
            e = exp_q.pop_front();
            if (ob !== e.b || cyc != e.c) begin
              errors++;
              $display("FAIL sb_byte: got %h at cycle %0d, required %h at cycle %0d",
                       ob, cyc, e.b, e.c);
            end
          end
        end
      end
    join_none

    test_reset();
    test_insert();
    test_replace();
    test_pass();
    test_short();
    test_gap_violation();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
